// File: rtl/nlc_pkg.sv
// nlc_pkg: shared float-to-fixed constants and SMC float field layout.
package nlc_pkg;
  localparam int FP_BIAS = 127;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int NUM_CH = 16;
  localparam int OUT_W = 21;
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } smc_float_t;
endpackage

// File: rtl/smc2fp_core.sv
// smc2fp_core: 2-stage SMC float to signed fixed-point conversion (rounds when SMC2FP_ROUND_EN is defined).
module smc2fp_core #(
  parameter int OW = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [3:0]    i_ch,
  input  logic [31:0]   i_float,
  output logic          o_valid,
  output logic [3:0]    o_ch,
  output logic [OW-1:0] o_val,
  output logic          o_sat
);
  import nlc_pkg::*;
`ifdef SMC2FP_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif
  localparam logic [EXP_W-1:0] EXP_LO = EXP_W'(FP_BIAS - 1);
  localparam logic [EXP_W-1:0] EXP_HI = EXP_W'(FP_BIAS + OW);
  localparam logic [EXP_W-1:0] SH_BASE = EXP_W'(FP_BIAS + MAN_W);
  localparam logic [MAN_W+1:0] LIM = (MAN_W+2)'(1) << (OW - 1);
  localparam logic [MAN_W+1:0] LIM_M1 = LIM - 1'b1;
  localparam logic [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};
  smc_float_t w_f;
  logic r_v1, r_sign1, r_zero1, r_big1;
  logic [4:0] r_sh1;
  logic [MAN_W:0] r_man1;
  logic [3:0] r_ch1;
  logic [MAN_W+1:0] w_t, w_mag;
  logic w_sat;
  logic [OW-1:0] w_val;
  assign w_f = i_float;
  always_ff @(posedge clk) begin
    r_v1 <= reset ? 1'b0 : i_valid;
    r_sign1 <= w_f.sign;
    r_zero1 <= w_f.exp < EXP_LO;
    r_big1 <= w_f.exp >= EXP_HI;
    r_sh1 <= 5'(SH_BASE - w_f.exp);
    r_man1 <= {1'b1, w_f.man};
    r_ch1 <= i_ch;
  end
  // w_t[0] is the first bit shifted out, i.e. the half-LSB used for rounding
  assign w_t = {r_man1, 1'b0} >> r_sh1;
  assign w_mag = {1'b0, w_t[MAN_W+1:1]} + {{(MAN_W+1){1'b0}}, w_t[0] & RND};
  assign w_sat = !r_zero1 & (r_big1 | (w_mag > (r_sign1 ? LIM : LIM_M1)));
  assign w_val = w_sat ? (r_sign1 ? MIN_V : MAX_V) :
                 r_zero1 ? '0 :
                 r_sign1 ? -w_mag[OW-1:0] : w_mag[OW-1:0];
  always_ff @(posedge clk) begin
    o_valid <= reset ? 1'b0 : r_v1;
    o_ch <= r_ch1;
    o_val <= w_val;
    o_sat <= w_sat;
  end
endmodule

// File: rtl/smc_float_to_fp_collect.sv
// smc_float_to_fp_collect: converts SMC floats per channel and collects them into frames.
// Rounding mode is selected by SMC2FP_ROUND_EN (defined: nearest/ties away, undefined: truncate).
module smc_float_to_fp_collect #(
  parameter int NUM_CH = nlc_pkg::NUM_CH,
  parameter int OUT_W = nlc_pkg::OUT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    srdyi,
  input  logic [3:0]              ch_idx,
  input  logic [31:0]             float_i,
  output logic [NUM_CH*OUT_W-1:0] x_lin_flat,
  output logic                    srdyo,
  output logic                    frame_sat,
  output logic                    dup_err
);
  logic w_v, w_sat, w_dup, w_done;
  logic [3:0] w_ch;
  logic [OUT_W-1:0] w_val;
  logic [NUM_CH-1:0] r_mask, w_bit, w_mask;
  logic r_sat;
  smc2fp_core #(.OW(OUT_W)) u_core (
    .clk(clk), .reset(reset), .i_valid(srdyi), .i_ch(ch_idx), .i_float(float_i),
    .o_valid(w_v), .o_ch(w_ch), .o_val(w_val), .o_sat(w_sat)
  );
  assign w_bit = NUM_CH'(1) << w_ch;
  assign w_mask = r_mask | w_bit;
  assign w_dup = |(r_mask & w_bit);
  assign w_done = &w_mask;
  always_ff @(posedge clk) begin
    if (reset) begin
      x_lin_flat <= '0;
      srdyo <= 1'b0;
      frame_sat <= 1'b0;
      dup_err <= 1'b0;
      r_mask <= '0;
      r_sat <= 1'b0;
    end else begin
      srdyo <= w_v & w_done;
      frame_sat <= w_v & w_done & (r_sat | w_sat);
      dup_err <= w_v & w_dup;
      if (w_v) begin
        x_lin_flat[OUT_W*w_ch +: OUT_W] <= w_val;
        r_mask <= w_done ? '0 : w_mask;
        r_sat <= !w_done & (r_sat | w_sat);
      end
    end
  end
endmodule

// File: doc/smc_float_to_fp_collect.md
SMC_FLOAT_TO_FP_COLLECT -- requirements
Module: smc_float_to_fp_collect

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, giving the number of channels collected per frame.
REQ-002 SHALL have parameter OUT_W, default 21, giving the width of each fixed-point output.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port srdyi, input, 1, meaning float_i and ch_idx are valid this cycle; one float is accepted per cycle and there is no backpressure.
REQ-006 SHALL have port ch_idx, input, 4, the destination channel of float_i.
REQ-007 SHALL have port float_i, input, 32, an SMC float result from the shared multiplier/adder datapath: bit 31 sign, bits 30:23 exponent with bias 127, bits 22:0 mantissa with hidden 1.
REQ-008 SHALL have port x_lin_flat, output, NUM_CH*OUT_W, holding channel k in bits [OUT_W*k+OUT_W-1 : OUT_W*k] as two's complement.
REQ-009 SHALL have port srdyo, output, 1, a single-cycle pulse meaning a full frame is present on x_lin_flat.
REQ-010 SHALL have port frame_sat, output, 1, set if any conversion in the completed frame saturated; valid only while srdyo is high.
REQ-011 SHALL have port dup_err, output, 1, a single-cycle pulse when a channel is written twice within one frame.

Function
REQ-012 SHALL convert in a 2-stage pipeline: stage 1 registers sign, the clipped exponent compare and the shift amount; stage 2 shifts, rounds, saturates and writes the bank. A float accepted at edge t is visible on x_lin_flat after edge t+2.
REQ-013 SHALL output 0 for an exponent of 0 (zero or denormal input) and for any magnitude below 0.5 (exponent below 126).
REQ-014 SHALL saturate a positive input to 2^(OUT_W-1)-1 and a negative input to -2^(OUT_W-1) when the rounded magnitude exceeds the range or the exponent is 255, and SHALL then set the sat flag.
REQ-015 SHALL treat -2^20 (0xC9800000) as exact, with no saturation.
REQ-016 SHALL keep a NUM_CH-bit written mask; each stage-2 write sets bit ch_idx.
REQ-017 SHALL pulse srdyo at the edge where the mask becomes all ones, and at that same edge SHALL clear the mask and the sticky sat flag.
REQ-018 SHALL let a write for the next frame arrive at stage 2 in the cycle after a completing write, with no lost data.
REQ-019 SHALL, on a duplicate write, overwrite the channel value, leave the mask unchanged and pulse dup_err together with that write.
REQ-020 SHALL hold x_lin_flat values between writes, since the bank is not cleared per frame.
REQ-021 SHALL leave the pipeline valid bits 0 in cycles with srdyi low, so no write occurs.

Reset
REQ-022 SHALL, on reset, clear x_lin_flat, srdyo, frame_sat, dup_err, the mask, the sat flag and both pipeline valid bits to 0 at the next edge.
REQ-023 SHALL discard any float in flight when reset is asserted mid-frame or mid-pipeline, so no srdyo pulse results from a partial frame.

Configuration
REQ-024 SHALL, with SMC2FP_ROUND_EN defined, round to nearest with ties away from zero.
REQ-025 SHALL, without SMC2FP_ROUND_EN, truncate toward zero; latency is identical either way.

Structure
REQ-026 SHALL place in shared package nlc_pkg the constants FP_BIAS=127, EXP_W=8, MAN_W=23, NUM_CH and OUT_W, plus the SMC float field-extraction typedef.
REQ-027 SHALL contain one sub-module, smc2fp_core, implementing the 2-stage conversion; collection, mask and flags live in the top level.

Verification
REQ-028 SHALL cover: 0x47000000 on ch3 -> ch3 = 32768 two edges later; other channels unchanged.
REQ-029 SHALL cover: 0xC0200000 (-2.5) on ch0 -> 0x1FFFFD (-3) with ROUND_EN, 0x1FFFFE (-2) without; 0x3F000000 (0.5) -> 1 with ROUND_EN, 0 without; 0x3EFFFFFF -> 0.
REQ-030 SHALL cover: 0x4A000000 -> 0x0FFFFF and 0xCA000000 -> 0x100000, both with frame_sat=1 at frame end; 0xC9800000 -> 0x100000 with frame_sat=0.
REQ-031 SHALL cover: ch0..ch15 on consecutive cycles 0..15 -> exactly one srdyo pulse after edge 17; a second back-to-back frame starting at cycle 16 -> second pulse after edge 33.
REQ-032 SHALL cover: ch5 written twice, then the remaining channels -> one dup_err pulse, ch5 holds the second value, srdyo once after the 16 distinct channels.
REQ-033 SHALL cover: reset pulsed after 8 channels -> bank all zero, no srdyo; then a full 16-channel frame -> single srdyo.
